// File: rtl/chan_token_pkg.sv
// Shared state encoding and arbitration-mode constants for the channel token controller.
package chan_token_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// Combinational wrap-around priority search: round-robin from ptr, or lowest index in fixed mode.
module rr_pick
  import chan_token_pkg::*;
#(
  parameter int NCH = 8,
  parameter int PW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  input  logic           mode,
  output logic [NCH-1:0] win,
  output logic           valid
);

  logic          found;
  logic [PW-1:0] sel;
  int            s;

  always_comb begin
    win   = '0;
    found = 1'b0;
    sel   = '0;
    s     = 0;
    for (int k = 0; k < NCH; k++) begin
      s = (mode == MODE_FIXED) ? k : int'(ptr) + k;
      if (s >= NCH) s = s - NCH;
      sel = PW'(s);
      if (!found && req[sel]) begin
        win[sel] = 1'b1;
        found    = 1'b1;
      end
    end
    valid = |req;
  end

endmodule

// File: rtl/chan_token_ctrl.sv
// Channel token controller: grants one requesting channel for HOLD_LEN+1 cycles,
// with round-robin or fixed-priority arbitration and gated data output.
//
//   state    | meaning
//   ST_IDLE  | no grant; arbitrate when EN=1 and any REQ set
//   ST_GRANT | one channel holds the token; counter runs down to release
module chan_token_ctrl
  import chan_token_pkg::*;
#(
  parameter int NCH    = 8,
  parameter int HOLD_W = 4,
  parameter int PW     = $clog2(NCH)
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              EN,
  input  logic              MODE,
  input  logic [HOLD_W-1:0] HOLD_LEN,
  input  logic [NCH-1:0]    REQ,
  input  logic [NCH-1:0]    DAT,
  output logic [NCH-1:0]    GNT,
  output logic [NCH-1:0]    OUT,
  output logic              BUSY,
  output logic [PW-1:0]     PTR
);

  state_e            state_q, state_d;
  logic [NCH-1:0]    gnt_q, gnt_d;
  logic [NCH-1:0]    out_q, out_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              mode_q, mode_d;

  logic [NCH-1:0]    win;
  logic              win_valid;
  logic [PW-1:0]     gidx;
  logic [PW-1:0]     ptr_adv;

  rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .mode  (MODE),
    .win   (win),
    .valid (win_valid)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_q[i]) gidx = PW'(i);
    end
    ptr_adv = (gidx == PW'(NCH - 1)) ? '0 : gidx + PW'(1);
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    out_d   = gnt_q & DAT;
    case (state_q)
      ST_IDLE: begin
        if (EN && win_valid) begin
          state_d = ST_GRANT;
          gnt_d   = win;
          cnt_d   = HOLD_LEN;
          mode_d  = MODE;
        end
      end
      ST_GRANT: begin
        // Abort wins over release and leaves the pointer where it was.
        if (!EN) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
        end else if ((gnt_q & REQ) == '0 || cnt_q == '0) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          if (mode_q == MODE_RR) ptr_d = ptr_adv;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      out_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_RR;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      out_q   <= out_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign GNT  = gnt_q;
  assign OUT  = out_q;
  assign BUSY = (state_q == ST_GRANT);
  assign PTR  = ptr_q;

endmodule

// File: tb/tb_chan_token_ctrl.sv
// Directed bench for chan_token_ctrl with a short random run checking grant invariants.
module tb_chan_token_ctrl;
  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       EN = 1'b0;
  logic       MODE = 1'b0;
  logic [3:0] HOLD_LEN = '0;
  logic [7:0] REQ = '0;
  logic [7:0] DAT = '0;
  logic [7:0] GNT;
  logic [7:0] OUT;
  logic       BUSY;
  logic [2:0] PTR;

  int n_chk  = 0;
  int n_pass = 0;

  chan_token_ctrl #(.NCH(8), .HOLD_W(4)) dut (
    .CK(CK), .RN(RN), .EN(EN), .MODE(MODE), .HOLD_LEN(HOLD_LEN),
    .REQ(REQ), .DAT(DAT), .GNT(GNT), .OUT(OUT), .BUSY(BUSY), .PTR(PTR)
  );

  always #5 CK = ~CK;

  task automatic step;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset;
    #3;
    n_chk++; if (GNT !== 8'h00) $display("FAIL reset_gnt got %h want 00", GNT); else n_pass++;
    n_chk++; if (OUT !== 8'h00) $display("FAIL reset_out got %h want 00", OUT); else n_pass++;
    n_chk++; if (BUSY !== 1'b0) $display("FAIL reset_busy got %b want 0", BUSY); else n_pass++;
    n_chk++; if (PTR !== 3'd0) $display("FAIL reset_ptr got %0d want 0", PTR); else n_pass++;
    @(negedge CK);
    RN = 1'b1;
    step;
    n_chk++; if (BUSY !== 1'b0 || GNT !== 8'h00) $display("FAIL idle_noreq busy %b gnt %h want 0/00", BUSY, GNT); else n_pass++;
  endtask

  task automatic test_round_robin;
    logic [7:0] eg;
    EN = 1'b1; MODE = 1'b0; HOLD_LEN = 4'd2; DAT = 8'h00; REQ = 8'hFF;
    for (int c = 0; c < 8; c++) begin
      eg = 8'(1 << c);
      for (int k = 0; k < 3; k++) begin
        step;
        n_chk++;
        if (GNT !== eg || BUSY !== 1'b1) $display("FAIL rr_grant ch%0d cyc%0d gnt %h busy %b want %h/1", c, k, GNT, BUSY, eg);
        else n_pass++;
      end
      step;
      if (c == 7) REQ = 8'h00;
      n_chk++;
      if (GNT !== 8'h00 || BUSY !== 1'b0) $display("FAIL rr_gap ch%0d gnt %h busy %b want 00/0", c, GNT, BUSY);
      else n_pass++;
      n_chk++;
      if (PTR !== 3'((c + 1) % 8)) $display("FAIL rr_ptr ch%0d got %0d want %0d", c, PTR, (c + 1) % 8);
      else n_pass++;
    end
  endtask

  task automatic test_fixed;
    MODE = 1'b1; HOLD_LEN = 4'd0; REQ = 8'b1010_0000;
    for (int g = 0; g < 3; g++) begin
      step;
      n_chk++; if (GNT !== 8'h20) $display("FAIL fixed_gnt #%0d got %h want 20", g, GNT); else n_pass++;
      step;
      n_chk++; if (GNT !== 8'h00 || PTR !== 3'd0) $display("FAIL fixed_rel #%0d gnt %h ptr %0d want 00/0", g, GNT, PTR); else n_pass++;
    end
    REQ = 8'h00; MODE = 1'b0;
    step;
  endtask

  task automatic test_abort;
    REQ = 8'h04; HOLD_LEN = 4'd0;
    step;
    step;
    n_chk++; if (PTR !== 3'd3) $display("FAIL abort_prep ptr got %0d want 3", PTR); else n_pass++;
    REQ = 8'h08; HOLD_LEN = 4'd5; DAT = 8'h08;
    step;
    n_chk++; if (GNT !== 8'h08 || OUT !== 8'h00) $display("FAIL abort_c1 gnt %h out %h want 08/00", GNT, OUT); else n_pass++;
    step;
    n_chk++; if (GNT !== 8'h08 || OUT !== 8'h08) $display("FAIL abort_c2 gnt %h out %h want 08/08", GNT, OUT); else n_pass++;
    EN = 1'b0;
    step;
    n_chk++; if (GNT !== 8'h00 || BUSY !== 1'b0) $display("FAIL abort_drop gnt %h busy %b want 00/0", GNT, BUSY); else n_pass++;
    n_chk++; if (PTR !== 3'd3) $display("FAIL abort_ptr got %0d want 3", PTR); else n_pass++;
    n_chk++; if (OUT !== 8'h08) $display("FAIL abort_out_tail got %h want 08", OUT); else n_pass++;
    step;
    n_chk++; if (OUT !== 8'h00) $display("FAIL abort_out_end got %h want 00", OUT); else n_pass++;
    EN = 1'b1; REQ = 8'h00; DAT = 8'h00;
    step;
  endtask

  task automatic test_early_release;
    REQ = 8'h20; HOLD_LEN = 4'd7; MODE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      n_chk++; if (GNT !== 8'h20) $display("FAIL early_hold cyc%0d got %h want 20", k, GNT); else n_pass++;
      HOLD_LEN = 4'd0; MODE = 1'b1;
    end
    REQ = 8'h00;
    step;
    n_chk++; if (GNT !== 8'h00 || BUSY !== 1'b0) $display("FAIL early_drop gnt %h busy %b want 00/0", GNT, BUSY); else n_pass++;
    n_chk++; if (PTR !== 3'd6) $display("FAIL early_ptr got %0d want 6", PTR); else n_pass++;
    MODE = 1'b0;
    step;
  endtask

  task automatic test_reset_mid;
    REQ = 8'hFF; HOLD_LEN = 4'd3; DAT = 8'hFF;
    step;
    n_chk++; if (GNT !== 8'h40) $display("FAIL rstmid_pre gnt got %h want 40", GNT); else n_pass++;
    step;
    n_chk++; if (OUT !== 8'h40) $display("FAIL rstmid_pre out got %h want 40", OUT); else n_pass++;
    #2 RN = 1'b0;
    #1;
    n_chk++;
    if (GNT !== 8'h00 || OUT !== 8'h00 || BUSY !== 1'b0 || PTR !== 3'd0)
      $display("FAIL rstmid_async gnt %h out %h busy %b ptr %0d want 00/00/0/0", GNT, OUT, BUSY, PTR);
    else n_pass++;
    RN = 1'b1;
    step;
    n_chk++; if (GNT !== 8'h01) $display("FAIL rstmid_first gnt got %h want 01", GNT); else n_pass++;
    EN = 1'b0;
    step;
    EN = 1'b1; REQ = 8'h00; DAT = 8'h00;
    step;
  endtask

  task automatic test_hold_zero;
    logic       md [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] eg [4] = '{8'h01, 8'h01, 8'h01, 8'h80};
    logic [2:0] ep [4] = '{3'd0, 3'd1, 3'd1, 3'd0};
    HOLD_LEN = 4'd0; REQ = 8'h81;
    for (int g = 0; g < 4; g++) begin
      MODE = md[g];
      step;
      n_chk++; if (GNT !== eg[g]) $display("FAIL hz_gnt #%0d got %h want %h", g, GNT, eg[g]); else n_pass++;
      step;
      n_chk++; if (GNT !== 8'h00 || PTR !== ep[g]) $display("FAIL hz_rel #%0d gnt %h ptr %0d want 00/%0d", g, GNT, PTR, ep[g]); else n_pass++;
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 300; i++) begin
      EN       = ($urandom_range(0, 9) != 0);
      MODE     = 1'($urandom_range(0, 1));
      HOLD_LEN = 4'($urandom_range(0, 3));
      REQ      = 8'($urandom);
      DAT      = 8'($urandom);
      step;
      n_chk++;
      if (!$onehot0(GNT) || BUSY !== (GNT != 8'h00))
        $display("FAIL rand_onehot cyc%0d gnt %h busy %b want onehot0 and busy==|gnt", i, GNT, BUSY);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_fixed;
    test_abort;
    test_early_release;
    test_reset_mid;
    test_hold_zero;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
